// File: rtl/jedro_1_dmem_resp_pkg.sv
// Shared widths, FSM state encoding and byte-lane helper for the jedro_1 data-memory responder.
package jedro_1_dmem_resp_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned NUM_LANES  = DATA_WIDTH / 8;

   typedef enum logic [0:0] {
      DMEM_ST_IDLE = 1'b0,
      DMEM_ST_WAIT = 1'b1
   } dmem_state_e;

   // Expand per-lane enables into a full-width bit mask.
   function automatic logic [DATA_WIDTH-1:0] be_mask(input logic [NUM_LANES-1:0] be);
      logic [DATA_WIDTH-1:0] mask;
      mask = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         mask[8*i +: 8] = {8{be[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/jedro_1_dmem_resp_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module jedro_1_dmem_ram
   import jedro_1_dmem_resp_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 1024,
   parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
   input  logic                  clk_i,
   input  logic                  en_i,
   input  logic                  we_i,
   input  logic [NUM_LANES-1:0]  be_i,
   input  logic [AW-1:0]         addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Contents are deliberately left unreset so the array maps onto block RAM.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (we_i && be_i[i]) begin
               mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/jedro_1_dmem_resp.sv
// Data-memory responder for the jedro_1 core req/gnt/rvalid interface.
// Optional error checking is enabled by defining JEDRO_1_DMEM_ERR_EN.
module jedro_1_dmem_resp
   import jedro_1_dmem_resp_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned GNT_DELAY = 0
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  data_req_i,
   output logic                  data_gnt_o,
   output logic                  data_rvalid_o,
   input  logic                  data_we_i,
   input  logic [NUM_LANES-1:0]  data_be_i,
   input  logic [31:0]           data_addr_i,
   input  logic [DATA_WIDTH-1:0] data_wdata_i,
   output logic [DATA_WIDTH-1:0] data_rdata_o,
   output logic                  data_err_o
);

   localparam int unsigned AW = $clog2(MEM_WORDS);

   dmem_state_e           state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  gnt;
   logic                  rvalid_q;
   logic                  err_q;
   logic                  zero_q;
   logic [NUM_LANES-1:0]  be_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic [DATA_WIDTH-1:0] resp_data;
   logic [31:0]           addr_off;
   logic [AW-1:0]         word_idx;
   logic                  txn_err;

   assign addr_off = data_addr_i - BASE_ADDR;
   assign word_idx = addr_off[AW+1:2];

`ifdef JEDRO_1_DMEM_ERR_EN
   assign txn_err = (addr_off >= 32'(4 * MEM_WORDS)) || (addr_off[1:0] != 2'b00) ||
                    (data_be_i == '0);
`else
   logic unused_addr_bits;
   assign txn_err          = 1'b0;
   assign unused_addr_bits = ^{addr_off[31:AW+2], addr_off[1:0]};
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt     = 1'b0;
      case (state_q)
         DMEM_ST_IDLE: begin
            if (data_req_i) begin
               if (GNT_DELAY == 0) begin
                  gnt = 1'b1;
               end else begin
                  cnt_d   = 4'(GNT_DELAY - 1);
                  state_d = DMEM_ST_WAIT;
               end
            end
         end
         DMEM_ST_WAIT: begin
            if (!data_req_i) begin
               state_d = DMEM_ST_IDLE;
            end else if (cnt_q == 4'd0) begin
               gnt     = 1'b1;
               state_d = DMEM_ST_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = DMEM_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q  <= DMEM_ST_IDLE;
         cnt_q    <= 4'd0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         zero_q   <= 1'b0;
         be_q     <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rvalid_q <= gnt;
         if (gnt) begin
            err_q  <= txn_err;
            zero_q <= data_we_i | txn_err;
            be_q   <= data_be_i;
         end
         // Capture the response so it stays visible after rvalid drops.
         if (rvalid_q) begin
            rdata_q <= resp_data;
         end
      end
   end

   jedro_1_dmem_ram #(
      .MEM_WORDS (MEM_WORDS),
      .AW        (AW)
   ) u_ram (
      .clk_i   (clk_i),
      .en_i    (gnt),
      .we_i    (data_we_i & ~txn_err),
      .be_i    (data_be_i),
      .addr_i  (word_idx),
      .wdata_i (data_wdata_i),
      .rdata_o (ram_rdata)
   );

   assign resp_data     = zero_q ? '0 : (ram_rdata & be_mask(be_q));
   assign data_gnt_o    = gnt;
   assign data_rvalid_o = rvalid_q;
   assign data_rdata_o  = rvalid_q ? resp_data : rdata_q;
   assign data_err_o    = rvalid_q & err_q;

endmodule

// File: tb/tb_jedro_1_dmem_resp.sv
// Directed bench for jedro_1_dmem_resp: one instance with zero grant delay, one with delay 3.
module tb_jedro_1_dmem_resp;

   logic        clk = 1'b0;
   logic        rstn;
   int          passed = 0;
   int          total  = 0;

   logic        req0, we0, gnt0, rvalid0, err0;
   logic [3:0]  be0;
   logic [31:0] addr0, wdata0, rdata0;
   logic        req3, we3, gnt3, rvalid3, err3;
   logic [3:0]  be3;
   logic [31:0] addr3, wdata3, rdata3;

   always #5 clk = ~clk;

   jedro_1_dmem_resp #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .GNT_DELAY(0)) dut0 (
      .clk_i(clk), .rstn_i(rstn), .data_req_i(req0), .data_gnt_o(gnt0),
      .data_rvalid_o(rvalid0), .data_we_i(we0), .data_be_i(be0), .data_addr_i(addr0),
      .data_wdata_i(wdata0), .data_rdata_o(rdata0), .data_err_o(err0));

   jedro_1_dmem_resp #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .GNT_DELAY(3)) dut3 (
      .clk_i(clk), .rstn_i(rstn), .data_req_i(req3), .data_gnt_o(gnt3),
      .data_rvalid_o(rvalid3), .data_we_i(we3), .data_be_i(be3), .data_addr_i(addr3),
      .data_wdata_i(wdata3), .data_rdata_o(rdata3), .data_err_o(err3));

   // Zero-delay transaction starting at a falling edge; returns at the next falling edge.
   task automatic txn0(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic g, output logic rv,
                       output logic [31:0] rd, output logic e);
      req0 = 1'b1; we0 = we; be0 = be; addr0 = addr; wdata0 = wdata;
      #1 g = gnt0;
      @(negedge clk);
      req0 = 1'b0;
      rv = rvalid0; rd = rdata0; e = err0;
      $display("dut0 %s addr=%h be=%b wdata=%h -> gnt=%b rvalid=%b rdata=%h err=%b",
               we ? "WR" : "RD", addr, be, wdata, g, rv, rd, e);
   endtask

   // Delayed transaction: lat = falling-edge cycles until gnt, -1 if none within the budget.
   task automatic txn3(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat, output logic rv,
                       output logic [31:0] rd);
      lat = -1;
      req3 = 1'b1; we3 = we; be3 = be; addr3 = addr; wdata3 = wdata;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (gnt3) begin
            lat = c;
            break;
         end
         @(negedge clk);
      end
      if (lat >= 0) @(negedge clk);
      req3 = 1'b0;
      rv = rvalid3; rd = rdata3;
      $display("dut3 %s addr=%h be=%b wdata=%h -> lat=%0d rvalid=%b rdata=%h",
               we ? "WR" : "RD", addr, be, wdata, lat, rv, rd);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      req0 = 0; we0 = 0; be0 = 0; addr0 = 0; wdata0 = 0;
      req3 = 0; we3 = 0; be3 = 0; addr3 = 0; wdata3 = 0;
      repeat (3) @(negedge clk);
      total++; if ({gnt0, rvalid0, err0} !== 3'b000) $display("FAIL reset_ctl got=%b exp=000", {gnt0, rvalid0, err0}); else passed++;
      total++; if (rdata0 !== 32'h0) $display("FAIL reset_rdata got=%h exp=00000000", rdata0); else passed++;
      total++; if ({gnt3, rvalid3, err3, rdata3} !== 35'h0) $display("FAIL reset_dut3 got=%h exp=0", {gnt3, rvalid3, err3, rdata3}); else passed++;
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic g, rv, e;
      logic [31:0] rd;
      txn0(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, g, rv, rd, e);
      total++; if (g !== 1'b1) $display("FAIL wr_gnt got=%b exp=1", g); else passed++;
      total++; if ({rv, rd, e} !== {1'b1, 32'h0, 1'b0}) $display("FAIL wr_resp got rv=%b rd=%h err=%b exp rv=1 rd=0 err=0", rv, rd, e); else passed++;
      txn0(1'b0, 4'b1111, 32'h10, 32'h0, g, rv, rd, e);
      total++; if (g !== 1'b1) $display("FAIL rd_gnt got=%b exp=1", g); else passed++;
      total++; if ({rv, rd, e} !== {1'b1, 32'hDEADBEEF, 1'b0}) $display("FAIL rd_resp got rv=%b rd=%h err=%b exp rv=1 rd=deadbeef err=0", rv, rd, e); else passed++;
      @(negedge clk);
      total++; if ({rvalid0, err0, rdata0} !== {1'b0, 1'b0, 32'hDEADBEEF}) $display("FAIL rd_hold got rv=%b err=%b rd=%h exp rv=0 err=0 rd=deadbeef", rvalid0, err0, rdata0); else passed++;
   endtask

   task automatic test_partial();
      logic g, rv, e;
      logic [31:0] rd;
      txn0(1'b1, 4'b0101, 32'h10, 32'h11223344, g, rv, rd, e);
      txn0(1'b0, 4'b1111, 32'h10, 32'h0, g, rv, rd, e);
      total++; if (rd !== 32'hDE22BE44) $display("FAIL partial_wr got=%h exp=de22be44", rd); else passed++;
      txn0(1'b0, 4'b0011, 32'h10, 32'h0, g, rv, rd, e);
      total++; if (rd !== 32'h0000BE44) $display("FAIL partial_rd got=%h exp=0000be44", rd); else passed++;
   endtask

   task automatic test_back_to_back();
      logic g, rv, e;
      logic [31:0] rd;
      logic [31:0] exp_d [3];
      exp_d[0] = 32'hA0A0A0A0; exp_d[1] = 32'hB1B1B1B1; exp_d[2] = 32'hC2C2C2C2;
      for (int i = 0; i < 3; i++) txn0(1'b1, 4'b1111, 32'(4 * i), exp_d[i], g, rv, rd, e);
      for (int i = 0; i <= 3; i++) begin
         if (i > 0) begin
            $display("dut0 b2b rsp %0d rvalid=%b rdata=%h", i - 1, rvalid0, rdata0);
            total++; if ({rvalid0, rdata0} !== {1'b1, exp_d[i-1]}) $display("FAIL b2b_rsp%0d got rv=%b rd=%h exp rv=1 rd=%h", i - 1, rvalid0, rdata0, exp_d[i-1]); else passed++;
         end
         if (i < 3) begin
            req0 = 1'b1; we0 = 1'b0; be0 = 4'b1111; addr0 = 32'(4 * i);
            #1;
            total++; if (gnt0 !== 1'b1) $display("FAIL b2b_gnt%0d got=%b exp=1", i, gnt0); else passed++;
         end else begin
            req0 = 1'b0;
         end
         @(negedge clk);
      end
      total++; if (rvalid0 !== 1'b0) $display("FAIL b2b_end got=%b exp=0", rvalid0); else passed++;
   endtask

   task automatic test_delay();
      int lat;
      logic rv;
      logic [31:0] rd;
      logic seen;
      txn3(1'b1, 4'b1111, 32'h20, 32'h12345678, lat, rv, rd);
      total++; if (lat !== 3) $display("FAIL delay_lat got=%0d exp=3", lat); else passed++;
      total++; if (rv !== 1'b1) $display("FAIL delay_rvalid got=%b exp=1", rv); else passed++;
      @(negedge clk);
      total++; if (rvalid3 !== 1'b0) $display("FAIL delay_rvalid_once got=%b exp=0", rvalid3); else passed++;
      // Withdraw a write after one cycle: it must never be granted or executed.
      req3 = 1'b1; we3 = 1'b1; be3 = 4'b1111; addr3 = 32'h20; wdata3 = 32'h0;
      @(negedge clk);
      req3 = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         #1 seen = seen | gnt3 | rvalid3;
         @(negedge clk);
      end
      $display("dut3 withdrawn WR addr=00000020 -> gnt_or_rvalid_seen=%b", seen);
      total++; if (seen !== 1'b0) $display("FAIL withdraw got=%b exp=0", seen); else passed++;
      txn3(1'b0, 4'b1111, 32'h20, 32'h0, lat, rv, rd);
      total++; if ({rv, rd} !== {1'b1, 32'h12345678}) $display("FAIL withdraw_data got rv=%b rd=%h exp rv=1 rd=12345678", rv, rd); else passed++;
   endtask

   task automatic test_reset_mid();
      int lat;
      logic rv;
      logic [31:0] rd;
      req3 = 1'b1; we3 = 1'b1; be3 = 4'b1111; addr3 = 32'h20; wdata3 = 32'hBAD0BAD0;
      req0 = 1'b1; we0 = 1'b0; be0 = 4'b1111; addr0 = 32'h10;
      @(negedge clk);
      req0 = 1'b0;
      total++; if ({rvalid0, rdata0} !== {1'b1, 32'hDE22BE44}) $display("FAIL rstmid_setup got rv=%b rd=%h exp rv=1 rd=de22be44", rvalid0, rdata0); else passed++;
      #2 rstn = 1'b0;
      #1;
      $display("async reset mid-op -> gnt3=%b rvalid0=%b rdata0=%h err0=%b", gnt3, rvalid0, rdata0, err0);
      total++; if ({gnt3, rvalid0, err0, rdata0} !== 35'h0) $display("FAIL rstmid_out got gnt3=%b rv=%b err=%b rd=%h exp all 0", gnt3, rvalid0, err0, rdata0); else passed++;
      req3 = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      txn3(1'b0, 4'b1111, 32'h20, 32'h0, lat, rv, rd);
      total++; if ({lat, rd} !== {32'sd3, 32'h12345678}) $display("FAIL rstmid_nowrite got lat=%0d rd=%h exp lat=3 rd=12345678", lat, rd); else passed++;
   endtask

   task automatic test_err();
      logic g, rv, e;
      logic [31:0] rd;
      txn0(1'b0, 4'b1111, 32'h1000, 32'h0, g, rv, rd, e);
`ifdef JEDRO_1_DMEM_ERR_EN
      total++; if ({rv, e, rd} !== {2'b11, 32'h0}) $display("FAIL err_range got rv=%b err=%b rd=%h exp rv=1 err=1 rd=0", rv, e, rd); else passed++;
`else
      total++; if ({rv, e, rd} !== {2'b10, 32'hA0A0A0A0}) $display("FAIL err_alias got rv=%b err=%b rd=%h exp rv=1 err=0 rd=a0a0a0a0", rv, e, rd); else passed++;
`endif
      txn0(1'b1, 4'b1111, 32'h2, 32'hFFFFFFFF, g, rv, rd, e);
`ifdef JEDRO_1_DMEM_ERR_EN
      total++; if ({rv, e} !== 2'b11) $display("FAIL err_misalign got rv=%b err=%b exp rv=1 err=1", rv, e); else passed++;
`else
      total++; if ({rv, e} !== 2'b10) $display("FAIL err_misalign got rv=%b err=%b exp rv=1 err=0", rv, e); else passed++;
`endif
      txn0(1'b0, 4'b1111, 32'h0, 32'h0, g, rv, rd, e);
`ifdef JEDRO_1_DMEM_ERR_EN
      total++; if (rd !== 32'hA0A0A0A0) $display("FAIL err_nowrite got=%h exp=a0a0a0a0", rd); else passed++;
`else
      total++; if (rd !== 32'hFFFFFFFF) $display("FAIL err_lowbits_ignored got=%h exp=ffffffff", rd); else passed++;
`endif
      txn0(1'b0, 4'b0000, 32'h4, 32'h0, g, rv, rd, e);
`ifdef JEDRO_1_DMEM_ERR_EN
      total++; if ({rv, e, rd} !== {2'b11, 32'h0}) $display("FAIL err_be0 got rv=%b err=%b rd=%h exp rv=1 err=1 rd=0", rv, e, rd); else passed++;
`else
      total++; if ({rv, e, rd} !== {2'b10, 32'h0}) $display("FAIL err_be0 got rv=%b err=%b rd=%h exp rv=1 err=0 rd=0", rv, e, rd); else passed++;
`endif
      @(negedge clk);
      total++; if (err0 !== 1'b0) $display("FAIL err_idle got=%b exp=0", err0); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_partial();
      test_back_to_back();
      test_delay();
      test_reset_mid();
      test_err();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
